// File: rtl/esc_pkg.sv
// ---------------------------------------------------------------------------
// esc_pkg
// Shared types and default constants for the quad ESC pulse driver.
//   state_t          : arm/disarm state machine encoding (IDLE, ARM, RUN)
//   DEF_PERIOD_W     : frame counter width, frame = 2^PERIOD_W clocks
//   DEF_MIN_PULSE    : pulse width in clocks for speed 0 (1 ms at 50 MHz)
//   DEF_SPD_MULT     : clocks added per speed LSB
//   DEF_ARM_FRAMES   : minimum-pulse frames sent before entering RUN
//   SPD_W            : width of one motor speed word
// ---------------------------------------------------------------------------
package esc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEF_PERIOD_W   = 20;
    localparam int DEF_MIN_PULSE  = 50000;
    localparam int DEF_SPD_MULT   = 24;
    localparam int DEF_ARM_FRAMES = 8;
    localparam int SPD_W          = 11;

endpackage

// File: rtl/esc_chan.sv
// ---------------------------------------------------------------------------
// esc_chan
// One ESC output channel: shadow speed register, pulse width computation and
// the registered pwm flop.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_cnt         : shared frame counter
//   i_frm_end     : high on the last cycle of the frame (cnt == all-ones)
//   i_load        : copy i_spd into the shadow register this cycle
//   i_run_mode    : 1 = width from shadow speed, 0 = minimum pulse (arming)
//   i_kill        : force pwm low and clear the shadow (no pulses allowed)
//   i_spd         : live speed from the flight controller
//   o_pwm         : registered ESC pulse
// ---------------------------------------------------------------------------
module esc_chan
    import esc_pkg::*;
#(
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int MIN_PULSE = DEF_MIN_PULSE,
    parameter int SPD_MULT  = DEF_SPD_MULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] i_cnt,
    input  logic                i_frm_end,
    input  logic                i_load,
    input  logic                i_run_mode,
    input  logic                i_kill,
    input  logic [SPD_W-1:0]    i_spd,
    output logic                o_pwm
);

    logic [SPD_W-1:0]    r_shadow;
    logic                r_pwm;
    logic [PERIOD_W-1:0] w_width;
    logic [PERIOD_W-1:0] w_last;

    // The shadow only changes on a frame boundary, so the width is stable for
    // the whole pulse. Legal parameters guarantee the sum fits in PERIOD_W.
    always_comb begin
        w_width = PERIOD_W'(MIN_PULSE);
        if (i_run_mode) begin
            w_width = PERIOD_W'(MIN_PULSE) + PERIOD_W'(r_shadow) * PERIOD_W'(SPD_MULT);
        end
        w_last = w_width - PERIOD_W'(1);
    end

    // Set on the edge leaving cnt==all-ones, cleared on the edge leaving
    // cnt==width-1: the pin is high for exactly width clocks from cnt==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_pwm    <= 1'b0;
        end else if (i_kill) begin
            r_shadow <= '0;
            r_pwm    <= 1'b0;
        end else begin
            if (i_load) begin
                r_shadow <= i_spd;
            end
            if (i_frm_end) begin
                r_pwm <= 1'b1;
            end else if (i_cnt == w_last) begin
                r_pwm <= 1'b0;
            end
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/esc_quad_drv.sv
// ---------------------------------------------------------------------------
// esc_quad_drv
// Four-channel servo-style ESC pulse generator with arm/disarm sequencing.
// One pulse per 2^PERIOD_W-clock frame on each motor line; speeds are
// double-buffered so a pulse never changes width mid-frame.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   arm                   : level, 1 requests motors enabled
//   spd_vld               : strobe, speed inputs hold a fresh result
//   frnt/bck/lft/rght_spd : 11-bit unsigned motor speeds
//   frnt/bck/lft/rght_pwm : registered ESC pulses
//   armed                 : high while in RUN
//   frm_end               : high on the last cycle of every frame
//   o_dbg_state           : current arm/disarm state
//
// spd_vld is a one-way strobe with no ready: the block always accepts it by
// raising upd_pend, and samples the speed inputs themselves only at the next
// RUN frame boundary, so the producer holds the speeds until that boundary.
// ---------------------------------------------------------------------------
module esc_quad_drv
    import esc_pkg::*;
#(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int MIN_PULSE  = DEF_MIN_PULSE,
    parameter int SPD_MULT   = DEF_SPD_MULT,
    parameter int ARM_FRAMES = DEF_ARM_FRAMES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             spd_vld,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             frnt_pwm,
    output logic             bck_pwm,
    output logic             lft_pwm,
    output logic             rght_pwm,
    output logic             armed,
    output logic             frm_end,
    output state_t           o_dbg_state
);

    localparam int AW = $clog2(ARM_FRAMES + 1);

    logic [PERIOD_W-1:0] r_cnt;
    state_t              r_state;
    logic [AW-1:0]       r_arm_cnt;
    logic                r_armed;
    logic                r_upd_pend;

    logic                w_frm_end;
    logic                w_last_arm;
    logic                w_load;
    logic                w_kill;
    logic                w_run_mode;
    logic [SPD_W-1:0]    w_spd [4];
    logic [3:0]          w_pwm;

    assign w_frm_end  = &r_cnt;
    assign w_last_arm = (r_arm_cnt == AW'(ARM_FRAMES - 1));
    assign w_run_mode = (r_state == RUN);

    // Shadow load at a frame boundary: forced on the ARM->RUN transition,
    // otherwise only in RUN with a pending update.
    assign w_load = w_frm_end && arm &&
                    (((r_state == ARM) && w_last_arm) ||
                     ((r_state == RUN) && r_upd_pend));

    // Pulses are allowed while armed, and on the IDLE frm_end that enters ARM
    // so the first arming pulse starts at cnt==0 of the next frame.
    assign w_kill = !(arm && ((r_state != IDLE) || w_frm_end));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

    // A spd_vld arriving on the load cycle itself stays pending for the
    // following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_pend <= 1'b0;
        end else begin
            r_upd_pend <= spd_vld | (r_upd_pend & ~w_load);
        end
    end

    // Disarm is immediate (not frame-aligned); arming is frame-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_frm_end && arm) begin
                        r_state   <= ARM;
                        r_arm_cnt <= '0;
                    end
                end
                ARM: begin
                    if (!arm) begin
                        r_state <= IDLE;
                    end else if (w_frm_end) begin
                        if (w_last_arm) begin
                            r_state <= RUN;
                            r_armed <= 1'b1;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + AW'(1);
                        end
                    end
                end
                RUN: begin
                    if (!arm) begin
                        r_state <= IDLE;
                        r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign w_spd[0] = frnt_spd;
    assign w_spd[1] = bck_spd;
    assign w_spd[2] = lft_spd;
    assign w_spd[3] = rght_spd;

    for (genvar g = 0; g < 4; g++) begin : g_chan
        esc_chan #(
            .PERIOD_W  (PERIOD_W),
            .MIN_PULSE (MIN_PULSE),
            .SPD_MULT  (SPD_MULT)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_cnt      (r_cnt),
            .i_frm_end  (w_frm_end),
            .i_load     (w_load),
            .i_run_mode (w_run_mode),
            .i_kill     (w_kill),
            .i_spd      (w_spd[g]),
            .o_pwm      (w_pwm[g])
        );
    end

    assign frnt_pwm    = w_pwm[0];
    assign bck_pwm     = w_pwm[1];
    assign lft_pwm     = w_pwm[2];
    assign rght_pwm    = w_pwm[3];
    assign armed       = r_armed;
    assign frm_end     = w_frm_end;
    assign o_dbg_state = r_state;

endmodule
